// File: rtl/colorizer_layered.sv
// Pixel compositor: merges sprite layers, a palette-mapped world map and an image ROM into RGB.
// Two-stage pipeline; the image ROM address leaves stage 1 and its data is consumed in stage 2.
module colorizer_layered #(
  parameter int unsigned NUM_LAYERS   = 4,
  parameter int unsigned COMP_W       = 4,
  localparam int unsigned COLOR_W     = 3 * COMP_W,
  parameter int unsigned ROW_DIV      = 3,
  parameter int unsigned COL_DIV      = 4,
  parameter int unsigned IMG_DIM_W    = 8,
  parameter logic [NUM_LAYERS-1:0] BLINK_MASK = '0,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [4*COLOR_W-1:0] PAL_RST = {12'h000, 12'h000, 12'h840, 12'hFFF},
  parameter logic [COLOR_W-1:0] BORDER_COLOR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [11:0]                    pixel_column,
  input  logic [11:0]                    pixel_row,
  input  logic                           video_on,
  input  logic [1:0]                     mode,
  input  logic [NUM_LAYERS*COLOR_W-1:0]  layer_color,
  input  logic [NUM_LAYERS-1:0]          layer_flag,
  input  logic [1:0]                     world_pixel,
  input  logic                           pal_we,
  input  logic [1:0]                     pal_addr,
  input  logic [COLOR_W-1:0]             pal_wdata,
  output logic [2*IMG_DIM_W-1:0]         img_addr,
  input  logic [COLOR_W-1:0]             img_data,
  output logic [COMP_W-1:0]              VGA_R,
  output logic [COMP_W-1:0]              VGA_G,
  output logic [COMP_W-1:0]              VGA_B
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [1:0] ModeGame  = 2'b01;
  localparam logic [1:0] ModeImage = 2'b10;

  logic [11:0] row_quot, col_quot;
  logic        oor_d;
  logic        at_origin, frame_evt;

  logic                          oor_q;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color_q;
  logic [NUM_LAYERS-1:0]         layer_flag_q;
  logic [1:0]                    world_pixel_q;
  logic [1:0]                    mode_q;
  logic                          video_on_q;
  logic                          blink_s1_q;

  logic             blink_visible_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             prev_origin_q;

  logic [COLOR_W-1:0]    palette_q [4];
  logic [NUM_LAYERS-1:0] eff_flag;
  logic [COLOR_W-1:0]    color_d, color_q;

  assign row_quot  = pixel_row / 12'(ROW_DIV);
  assign col_quot  = pixel_column / 12'(COL_DIV);
  assign oor_d     = ((row_quot >> IMG_DIM_W) != '0) || ((col_quot >> IMG_DIM_W) != '0);
  assign at_origin = (pixel_row == '0) && (pixel_column == '0);
  // Only the first cycle at (0,0) counts, so a held origin is a single frame start.
  assign frame_evt = at_origin && !prev_origin_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_addr      <= '0;
      oor_q         <= 1'b0;
      layer_color_q <= '0;
      layer_flag_q  <= '0;
      world_pixel_q <= '0;
      mode_q        <= '0;
      video_on_q    <= 1'b0;
      blink_s1_q    <= 1'b1;
    end else begin
      img_addr      <= {row_quot[IMG_DIM_W-1:0], col_quot[IMG_DIM_W-1:0]};
      oor_q         <= oor_d;
      layer_color_q <= layer_color;
      layer_flag_q  <= layer_flag;
      world_pixel_q <= world_pixel;
      mode_q        <= mode;
      video_on_q    <= video_on;
      blink_s1_q    <= blink_visible_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_visible_q <= 1'b1;
      frame_cnt_q     <= '0;
      prev_origin_q   <= 1'b0;
    end else begin
      prev_origin_q <= at_origin;
      if (frame_evt) begin
        if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_q     <= '0;
          blink_visible_q <= ~blink_visible_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) palette_q[i] <= PAL_RST[i*COLOR_W +: COLOR_W];
    end else if (pal_we) begin
      palette_q[pal_addr] <= pal_wdata;
    end
  end

  always_comb begin
    eff_flag = layer_flag_q & ~(BLINK_MASK & {NUM_LAYERS{~blink_s1_q}});
    color_d  = '0;
    if (video_on_q) begin
      case (mode_q)
        ModeImage: color_d = oor_q ? BORDER_COLOR : img_data;
        ModeGame: begin
          color_d = palette_q[world_pixel_q];
          // Walk from lowest priority up so the lowest set index wins.
          for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (eff_flag[i]) color_d = layer_color_q[i*COLOR_W +: COLOR_W];
          end
        end
        default: color_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) color_q <= '0;
    else       color_q <= color_d;
  end

  assign VGA_R = color_q[3*COMP_W-1 -: COMP_W];
  assign VGA_G = color_q[2*COMP_W-1 -: COMP_W];
  assign VGA_B = color_q[COMP_W-1:0];

endmodule

// File: tb/tb_colorizer_layered.sv
// Directed bench for colorizer_layered: priority, image addressing, palette writes, blink, reset.
module tb_colorizer_layered;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_column, pixel_row;
  logic        video_on;
  logic [1:0]  mode;
  logic [47:0] layer_color;
  logic [3:0]  layer_flag;
  logic [1:0]  world_pixel;
  logic        pal_we;
  logic [1:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic [15:0] img_addr;
  logic [11:0] img_data;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic [11:0] vga;

  int n_cmp = 0;
  int n_err = 0;

  colorizer_layered #(
    .BLINK_MASK   (4'b0001),
    .BLINK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_column (pixel_column),
    .pixel_row    (pixel_row),
    .video_on     (video_on),
    .mode         (mode),
    .layer_color  (layer_color),
    .layer_flag   (layer_flag),
    .world_pixel  (world_pixel),
    .pal_we       (pal_we),
    .pal_addr     (pal_addr),
    .pal_wdata    (pal_wdata),
    .img_addr     (img_addr),
    .img_data     (img_data),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  always #5 clk = ~clk;

  assign vga = {VGA_R, VGA_G, VGA_B};
  // Image ROM model: one known word, everything else a filler value.
  assign img_data = (img_addr == 16'h6464) ? 12'hABC : 12'h123;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int r, input int c, input logic von, input logic [1:0] m,
                     input logic [3:0] fl, input logic [1:0] wp);
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    video_on     = von;
    mode         = m;
    layer_flag   = fl;
    world_pixel  = wp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    layer_color = {12'h00F, 12'hF00, 12'h0F0, 12'h0FF};
    pal_we      = 1'b0;
    pal_addr    = 2'd0;
    pal_wdata   = 12'h000;
    pix(5, 5, 1'b0, 2'b00, 4'b0000, 2'd0);
    #12;
    check("reset_vga", 32'(vga), 32'h000);
    check("reset_img_addr", 32'(img_addr), 32'h0000);
    reset = 1'b0;
    tick();

    // Layer priority and palette fallback
    pix(5, 5, 1'b1, 2'b01, 4'b0110, 2'd0);
    tick(); tick();
    check("prio_l1_over_l2", 32'(vga), 32'h0F0);
    pix(5, 5, 1'b1, 2'b01, 4'b0000, 2'd0);
    tick(); tick();
    check("pal0_fallback", 32'(vga), 32'hFFF);

    // Asynchronous reset mid-line
    pix(5, 7, 1'b1, 2'b01, 4'b0100, 2'd0);
    tick(); tick();
    check("pre_reset_l2", 32'(vga), 32'hF00);
    #3 reset = 1'b1;
    #1;
    check("async_reset_vga", 32'(vga), 32'h000);
    check("async_reset_img_addr", 32'(img_addr), 32'h0000);
    #1 reset = 1'b0;
    pix(5, 8, 1'b1, 2'b01, 4'b0000, 2'd1);
    tick(); tick();
    check("reset_pal1", 32'(vga), 32'h840);

    // Image addressing and border
    pix(300, 400, 1'b1, 2'b10, 4'b0000, 2'd0);
    tick();
    check("img_addr_300_400", 32'(img_addr), 32'h6464);
    tick();
    check("img_data_out", 32'(vga), 32'hABC);
    pix(3, 8, 1'b1, 2'b10, 4'b0000, 2'd0);
    tick();
    check("img_addr_3_8", 32'(img_addr), 32'h0102);
    tick();
    check("img_filler_out", 32'(vga), 32'h123);
    pix(780, 400, 1'b1, 2'b10, 4'b0000, 2'd0);
    tick();
    check("img_addr_oor", 32'(img_addr), 32'h0464);
    tick();
    check("img_border", 32'(vga), 32'h000);

    // Blanking
    pix(5, 5, 1'b0, 2'b01, 4'b0110, 2'd0);
    tick(); tick();
    check("video_off_game", 32'(vga), 32'h000);
    pix(300, 400, 1'b0, 2'b10, 4'b0000, 2'd0);
    tick(); tick();
    check("video_off_image", 32'(vga), 32'h000);
    pix(5, 5, 1'b1, 2'b11, 4'b0110, 2'd0);
    tick(); tick();
    check("mode11_blank", 32'(vga), 32'h000);
    pix(5, 5, 1'b1, 2'b00, 4'b0110, 2'd0);
    tick(); tick();
    check("mode00_blank", 32'(vga), 32'h000);

    // Palette write racing a lookup of the same entry
    pix(5, 5, 1'b1, 2'b01, 4'b0000, 2'd2);
    tick();
    pal_we    = 1'b1;
    pal_addr  = 2'd2;
    pal_wdata = 12'h00F;
    tick();
    pal_we = 1'b0;
    check("pal_write_old", 32'(vga), 32'h000);
    tick();
    check("pal_write_new", 32'(vga), 32'h00F);

    // Blink: two frames visible, two hidden; a held origin is one frame
    reset = 1'b1;
    pix(5, 5, 1'b0, 2'b00, 4'b0000, 2'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        for (int h = 0; h < ((k == 2) ? 5 : 1); h++) begin
          pix(0, 0, 1'b1, 2'b01, 4'b0001, 2'd0);
          tick();
        end
      end
      pix(5, 5, 1'b1, 2'b01, 4'b0001, 2'd0);
      tick(); tick();
      check($sformatf("blink_frame%0d", k), 32'(vga),
            (((k / 2) % 2) == 0) ? 32'h0FF : 32'hFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/colorizer_layered.md
Name: colorizer_layered

Overview:
Parameterised pixel compositor between the VGA timing generator and the board's VGA pins. It merges NUM_LAYERS sprite layers, a palette-mapped 2-bit world map and one external full-screen image ROM into a single RGB pixel.
- Fixed pipeline latency; image ROM address and data are aligned by construction.
- Adds over its predecessor: run-time palette writes, per-layer blink and out-of-range border handling.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 has the highest priority.
- COMP_W, 4, bits per colour component; COLOR_W = 3*COMP_W.
- ROW_DIV, 3, image vertical scale divisor (constant).
- COL_DIV, 4, image horizontal scale divisor (constant).
- IMG_DIM_W, 8, image side is 2^IMG_DIM_W pixels; img_addr width is 2*IMG_DIM_W.
- BLINK_MASK, 0, NUM_LAYERS-bit mask of layers that blink.
- BLINK_FRAMES, 30, number of frames per blink phase (must be at least 1).
- PAL_RST, {12'h000,12'h000,12'h840,12'hFFF}, reset palette, entry 0 in the LSBs.
- BORDER_COLOR, 12'h000, colour for image pixels outside the image.

Ports:
- clk, input, 1, pixel clock.
- reset, input, 1, asynchronous active-high reset.
- pixel_column, input, 12, current column from the timing generator.
- pixel_row, input, 12, current row from the timing generator.
- video_on, input, 1, active-display qualifier.
- mode, input, 2, 00 blank, 01 game, 10 image, 11 reserved.
- layer_color, input, NUM_LAYERS*COLOR_W, packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_flag, input, NUM_LAYERS, layer i is opaque at this pixel.
- world_pixel, input, 2, map palette index.
- pal_we, input, 1, palette write strobe.
- pal_addr, input, 2, palette entry to write.
- pal_wdata, input, COLOR_W, palette write data.
- img_addr, output, 2*IMG_DIM_W, synchronous ROM address (registered).
- img_data, input, COLOR_W, ROM data, valid one clk after img_addr.
- VGA_R, output, COMP_W, red component.
- VGA_G, output, COMP_W, green component.
- VGA_B, output, COMP_W, blue component.

Behaviour:
- Reset (async, active-high):
  - VGA_R/G/B = 0, img_addr = 0.
  - All pipeline registers cleared (video_on and mode to 0).
  - Palette loaded from PAL_RST; blink_visible = 1; frame count = 0.
- Pipeline: outputs at cycle N+2 reflect inputs sampled at cycle N.
  - Stage 1 (clock edge after N):
    - Registers the following signals:
      - img_addr = {row_q, col_q}, where row_q = pixel_row/ROW_DIV and col_q = pixel_column/COL_DIV, each truncated to IMG_DIM_W bits.
      - oor = (row_q >= 2^IMG_DIM_W) or (col_q >= 2^IMG_DIM_W), using the untruncated quotients.
      - layer_color, layer_flag, world_pixel, mode, video_on.
      - blink_visible.
  - Stage 2: registers VGA_R/G/B; img_data is consumed here.
- Output selection (stage 2, using stage-1 values):
  - video_on = 0, or mode 00 or 11: output 0.
  - Mode 10 (image): output BORDER_COLOR if oor, else img_data.
  - Mode 01 (game):
    - eff_flag[i] = layer_flag[i] AND NOT (BLINK_MASK[i] AND NOT blink_visible).
    - Output the colour of the lowest-index layer with eff_flag set.
    - If no layer is set, output palette[world_pixel].
  - Output packing: {VGA_R, VGA_G, VGA_B} = colour, with R in the MSBs.
- Palette:
  - 4 x COLOR_W registers; written on clk when pal_we = 1.
  - A lookup in the same cycle as a write to that entry returns the old value; the new value is returned from the next cycle.
- Blink:
  - Frame-start event: pixel_row == 0 and pixel_column == 0 this cycle, and the previous sampled (row, col) was not (0, 0). Holding at (0, 0) produces one event only.
  - On each event the frame count increments.
  - When the count reaches BLINK_FRAMES-1 and an event occurs, the count wraps to 0 and blink_visible toggles.
- Mode changes are pipeline-aligned: no pixel mixes the old and new mode.
- Reset asserted mid-frame: outputs go to 0 immediately. Normal output resumes 2 clocks after the first sampled pixel following reset release.

Test Plan:
- Reset: assert reset asynchronously mid-line -> VGA = 0 within the same cycle, img_addr = 0, palette[1] reads 12'h840 (mode 01, world_pixel = 1, no flags -> 12'h840 two clocks later).
- Layer priority: mode 01, layer_flag = 4'b0110, layer1 = 12'h0F0, layer2 = 12'hF00 -> 12'h0F0 at N+2. layer_flag = 0, world_pixel = 0 -> 12'hFFF.
- Image addressing: mode 10, row = 300, col = 400 -> img_addr = 16'h6464 at N+1. ROM model returns 12'hABC -> VGA = 12'hABC at N+2. row = 780 -> BORDER_COLOR 12'h000.
- Palette write: pal_we with addr 2, data 12'h00F, in the same cycle as a world_pixel = 2 lookup -> old 12'h000 that pixel, 12'h00F from the next pixel.
- Blink: BLINK_MASK = 4'b0001, BLINK_FRAMES = 2, layer 0 flagged continuously -> layer 0 colour for 2 frames, palette colour for 2 frames, repeating. Holding (0, 0) for 5 cycles counts as one frame.
- video_on = 0 in any mode with layers active -> 12'h000 at N+2; mode 11 -> 12'h000.
